// File: rtl/bus_arbiter_if.sv
// Shared peripheral bus between the arbiter (master) and the addressed peripheral (slave).
interface bus_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              o_bus_clk;
    logic              o_bus_we;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [DATA_W-1:0] o_bus_data;
    logic [DATA_W-1:0] i_bus_data;
    logic              i_bus_data_ready;

    modport master (output o_bus_clk, o_bus_we, o_bus_addr, o_bus_data,
                    input  i_bus_data, i_bus_data_ready);
    modport slave  (input  o_bus_clk, o_bus_we, o_bus_addr, o_bus_data,
                    output i_bus_data, i_bus_data_ready);
endinterface

// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter and strobe/ready sequencer for the external peripheral bus.
// Port 0 is the CPU core, port 1 the secondary master (DMA / video fetch).
module bus_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic              o_err0,
    output logic              o_err1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_grant,
    output logic              o_busy,
    bus_arbiter_if.master     bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    // Last STROBE cycle index before giving up; the wait is TIMEOUT cycles in total.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [7:0]        cnt, cnt_nx;
    logic              last, last_nx;
    logic              sel, grant_nx;
    logic              bclk_nx, we_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] data_nx, rdata_nx;
    logic              ack0_nx, ack1_nx, err0_nx, err1_nx;

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            last           <= 1'b1;
            o_grant        <= 1'b0;
            bus.o_bus_clk  <= 1'b0;
            bus.o_bus_we   <= 1'b0;
            bus.o_bus_addr <= '0;
            bus.o_bus_data <= '0;
            o_rdata        <= '0;
            o_ack0         <= 1'b0;
            o_ack1         <= 1'b0;
            o_err0         <= 1'b0;
            o_err1         <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            last           <= last_nx;
            o_grant        <= grant_nx;
            bus.o_bus_clk  <= bclk_nx;
            bus.o_bus_we   <= we_nx;
            bus.o_bus_addr <= addr_nx;
            bus.o_bus_data <= data_nx;
            o_rdata        <= rdata_nx;
            o_ack0         <= ack0_nx;
            o_ack1         <= ack1_nx;
            o_err0         <= err0_nx;
            o_err1         <= err1_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        sel      = last;
        grant_nx = o_grant;
        bclk_nx  = bus.o_bus_clk;
        we_nx    = bus.o_bus_we;
        addr_nx  = bus.o_bus_addr;
        data_nx  = bus.o_bus_data;
        rdata_nx = o_rdata;
        ack0_nx  = 1'b0;
        ack1_nx  = 1'b0;
        err0_nx  = 1'b0;
        err1_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    // On a tie the port that did not win last time gets the bus.
                    sel      = (i_req0 && i_req1) ? ~last : i_req1;
                    grant_nx = sel;
                    we_nx    = sel ? i_we1    : i_we0;
                    addr_nx  = sel ? i_addr1  : i_addr0;
                    data_nx  = sel ? i_wdata1 : i_wdata0;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                cnt_nx   = '0;
                bclk_nx  = 1'b1;
                state_nx = STROBE;
            end
            STROBE: begin
                if (bus.i_bus_data_ready) begin
                    bclk_nx = 1'b0;
                    if (!bus.o_bus_we) rdata_nx = bus.i_bus_data;
                    ack0_nx  = ~o_grant;
                    ack1_nx  = o_grant;
                    state_nx = DONE;
                end else if (cnt == TO_LAST) begin
                    bclk_nx  = 1'b0;
                    rdata_nx = '1;
                    ack0_nx  = ~o_grant;
                    ack1_nx  = o_grant;
                    err0_nx  = ~o_grant;
                    err1_nx  = o_grant;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            DONE: begin
                last_nx  = o_grant;
                we_nx    = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-port arbiter and cycle sequencer for the CPU's external peripheral bus (o_bus_clk / o_bus_we / o_bus_addr / o_bus_data / i_bus_data / i_bus_data_ready). Port 0 is the CPU core; port 1 is a secondary master (DMA / text-video fetch). Accepts one request at a time under round-robin priority and runs the strobe/ready handshake on the shared bus. Returns read data with a one-cycle acknowledge, or an error on timeout.

## Interface

Parameters:
- DATA_W, 32, bus data width (matches the 32-bit `VW width).
- ADDR_W, 32, bus address width.
- TIMEOUT, 255, maximum cycles spent in STROBE waiting for ready; legal range 1..255.

Ports:
- i_cpu_clk  in  1  sole clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req0 / i_req1  in  1  request from port 0 / port 1; held high until that port's ack.
- i_we0 / i_we1  in  1  1 = write, 0 = read; stable while req is high.
- i_addr0 / i_addr1  in  ADDR_W  transaction address; stable while req is high.
- i_wdata0 / i_wdata1  in  DATA_W  write data; stable while req is high.
- o_ack0 / o_ack1  out  1  one-cycle completion pulse.
- o_err0 / o_err1  out  1  one-cycle pulse coincident with ack when the transaction timed out.
- o_rdata  out  DATA_W  read data; valid in the ack cycle, held until the next ack.
- o_grant  out  1  index of the port owning the current or last transaction.
- o_busy  out  1  high in any state other than IDLE.
- o_bus_clk  out  1  bus strobe.
- o_bus_we  out  1  bus write enable.
- o_bus_addr  out  ADDR_W  bus address.
- o_bus_data  out  DATA_W  bus write data.
- i_bus_data  in  DATA_W  bus read data.
- i_bus_data_ready  in  1  peripheral completion.

## Operation

- FSM states: IDLE, SETUP, STROBE, DONE.
- **IDLE**
  - Sample i_req0 and i_req1.
  - Neither high: stay in IDLE.
  - Exactly one high: grant that port.
  - Both high: grant the port that is not the last-granted port.
  - On grant: latch the port's we/addr/wdata into o_bus_we/o_bus_addr/o_bus_data, set o_grant, go to SETUP.
- **SETUP**
  - Bus address, data and we are driven; o_bus_clk = 0.
  - Clear the timeout counter. Go to STROBE.
- **STROBE**
  - o_bus_clk = 1.
  - i_bus_data_ready = 1: latch i_bus_data into o_rdata (reads only; writes leave o_rdata unchanged), clear o_bus_clk, go to DONE with err = 0.
  - Otherwise increment the counter (8-bit, no wrap needed).
  - Counter reaches TIMEOUT-1 without ready: clear o_bus_clk, set o_rdata = all-ones, go to DONE with err = 1.
  - Ready and timeout in the same cycle: ready wins, err = 0.
- **DONE**
  - Pulse o_ackN (and o_errN if flagged) for the granted port only.
  - Update last-granted = o_grant; o_bus_we returns to 0.
  - Requests are not sampled in this state. Go to IDLE.
- Back-to-back: a port may keep req high after its ack with new fields presented from the cycle after ack. It is re-sampled in IDLE under round-robin, so with both ports requesting continuously, grants alternate 0,1,0,1.
- o_bus_addr and o_bus_data hold their last values in IDLE; only o_bus_clk and o_bus_we are forced low.
- Requests dropped mid-transaction (protocol violation) do not abort the transaction; the ack is still issued.

## Timing

- Reset values (async, immediate on i_rst_n low):
  - state = IDLE.
  - o_bus_clk, o_bus_we, o_ack0/1, o_err0/1, o_busy, o_grant = 0.
  - o_bus_addr, o_bus_data, o_rdata = 0.
  - last-granted = 1, so port 0 wins the first tie.
- Reset mid-transaction: the strobe drops at once, no ack or err is issued, and the transaction is lost.
- Latency, with req first seen at IDLE edge n:
  - SETUP at n+1.
  - STROBE at n+2 (o_bus_clk high).
  - Ready sampled at edge n+2+k (k ≥ 0 wait cycles), giving DONE/ack at n+3+k.
  - Minimum request-to-ack is 3 cycles.
  - Minimum back-to-back spacing is 4 cycles per transaction.
- Timeout: ack/err asserts exactly TIMEOUT cycles after entering STROBE, i.e. at n+2+TIMEOUT.
- o_busy is high from SETUP through DONE inclusive.
- o_grant is stable from SETUP until the next grant.

## Test plan

- **Reset**: hold i_rst_n = 0 for 3 cycles mid-STROBE. Required: all outputs at reset values, no ack pulse, next tie grants port 0.
- **Single read**: port 0 reads addr 0x0000_1000, peripheral ready with 0xDEADBEEF on the first STROBE cycle. Required: o_ack0 exactly 3 cycles after req, o_rdata = 0xDEADBEEF, o_ack1 never pulses.
- **Single write with wait**: port 1 writes 0x12345678 to 0x0000_2004, ready 5 cycles into STROBE. Required: o_bus_we = 1 and addr/data stable throughout, o_bus_clk high for exactly 6 cycles, o_ack1 at n+8.
- **Contention**: both ports request continuously, 8 transactions. Required: grant order 0,1,0,1,0,1,0,1, with one ack per transaction on the matching port.
- **Timeout**: TIMEOUT = 16, ready never asserted. Required: o_ack0 and o_err0 at n+18, o_rdata = 0xFFFF_FFFF, o_bus_clk low.
- **Timeout tie**: ready asserts on the final timeout cycle. Required: ack with err = 0 and o_rdata equal to the bus data.
